// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_core execute-stage ALU.
//   ALU_WIDTH : default operand/result width
//   alu_op_e  : 3-bit operation encoding
//   is_sub()  : decode of the adder B-inversion / carry-in select
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_SLTU = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  // Both compares run through the adder as a subtraction, so they share the
  // B-inversion and carry-in of SUB.
  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SLTU) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_adder.sv
// alu_adder: WIDTH-bit adder with optional B inversion.
//   i_a, i_b      : operands
//   i_b_invert    : 1 selects ~i_b as the second operand
//   i_carry_in    : carry into bit 0
//   o_sum         : WIDTH-bit sum
//   o_carry_out   : carry out of the MSB
//   o_overflow    : raw signed overflow of the operation as performed
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_invert,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_full;

  assign w_bop       = i_b_invert ? ~i_b : i_b;
  assign w_full      = {1'b0, i_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, i_carry_in};
  assign o_sum       = w_full[WIDTH-1:0];
  assign o_carry_out = w_full[WIDTH];
  // Like-signed operands producing an opposite-signed sum.
  assign o_overflow  = (i_a[WIDTH-1] == w_bop[WIDTH-1]) &&
                       (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// alu_core: single-cycle integer ALU with registered result and flags.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   operation         : function select (alu_op_e encoding)
//   A, B              : operands
//   carry_in, B_invert: combinational adder controls decoded from operation
//   C                 : registered result
//   zero              : registered, set when the registered C is 0
//   overflow          : registered signed overflow (ADD/SUB only)
//   carry_out         : registered adder carry out (ADD/SUB only)
// Build option: define ALU_SAT_EN to saturate ADD/SUB results on signed
// overflow instead of wrapping.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             carry_in,
  output logic             B_invert,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf_raw;
  logic [WIDTH-1:0] w_result_p0;
  logic             w_ovf_p0;
  logic             w_cout_p0;

  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;
  logic             r_ovf_p1;
  logic             r_cout_p1;

`ifdef ALU_SAT_EN
  // Clamp to the signed extreme on overflow; the sign of A tells which way
  // the true result went, since both adder operands share that sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                input logic             ovf,
                                                input logic             a_msb);
    if (!ovf) return sum;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign B_invert = is_sub(operation);
  assign carry_in = is_sub(operation);

  alu_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .i_a        (A),
    .i_b        (B),
    .i_b_invert (B_invert),
    .i_carry_in (carry_in),
    .o_sum      (w_sum),
    .o_carry_out(w_cout),
    .o_overflow (w_ovf_raw)
  );

  // ---- stage p0: operation mux ----
  always_comb begin
    w_result_p0 = '0;
    w_ovf_p0    = 1'b0;
    w_cout_p0   = 1'b0;
    case (alu_op_e'(operation))
      OP_AND:  w_result_p0 = A & B;
      OP_OR:   w_result_p0 = A | B;
      OP_XOR:  w_result_p0 = A ^ B;
      OP_NOR:  w_result_p0 = ~(A | B);
      OP_ADD, OP_SUB: begin
`ifdef ALU_SAT_EN
        w_result_p0 = saturate(w_sum, w_ovf_raw, A[WIDTH-1]);
`else
        w_result_p0 = w_sum;
`endif
        w_ovf_p0    = w_ovf_raw;
        w_cout_p0   = w_cout;
      end
      // Unsigned A < B exactly when A - B borrows, i.e. no carry out.
      OP_SLTU: w_result_p0 = {{(WIDTH-1){1'b0}}, ~w_cout};
      // Sign of the difference, corrected when the subtraction overflowed.
      OP_SLT:  w_result_p0 = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
      default: w_result_p0 = '0;
    endcase
  end

  // ---- stage p1: registered result and flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b0;
      r_ovf_p1    <= 1'b0;
      r_cout_p1   <= 1'b0;
    end else begin
      r_result_p1 <= w_result_p0;
      r_zero_p1   <= (w_result_p0 == '0);
      r_ovf_p1    <= w_ovf_p0;
      r_cout_p1   <= w_cout_p0;
    end
  end

  assign C         = r_result_p1;
  assign zero      = r_zero_p1;
  assign overflow  = r_ovf_p1;
  assign carry_out = r_cout_p1;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [2:0]  operation;
  logic [31:0] A;
  logic [31:0] B;
  logic        carry_in;
  logic        B_invert;
  logic [31:0] C;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  // expected registered outputs currently held by the DUT
  logic [31:0] exp_c;
  logic        exp_z, exp_v, exp_co;

  alu_core #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .operation(operation),
    .A        (A),
    .B        (B),
    .carry_in (carry_in),
    .B_invert (B_invert),
    .C        (C),
    .zero     (zero),
    .overflow (overflow),
    .carry_out(carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic z, output logic v,
                                output logic co);
    longint          sa, sb, ss;
    longint unsigned ua, ub, us;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 32'd0; v = 1'b0; co = 1'b0; ss = 0;
    case (op)
      3'd0: c = a & b;
      3'd1: c = a | b;
      3'd3: c = a ^ b;
      3'd4: c = ~(a | b);
      3'd5: c = (ua < ub) ? 32'd1 : 32'd0;
      3'd7: c = (sa < sb) ? 32'd1 : 32'd0;
      3'd2: begin
        us = ua + ub; c = us[31:0]; co = us[32];
        ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: begin
        us = ua - ub; c = us[31:0]; co = (ua >= ub);
        ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
    endcase
`ifdef ALU_SAT_EN
    if (v) c = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    z = (c == 32'd0);
  endfunction

  // Apply one operation just after an edge, confirm decode and that the old
  // result is still held, then check the new result one edge later.
  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    logic sub;
    operation = op; A = a; B = b;
    #1;
    sub = (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
    chk({tag, "_binv"}, {31'd0, B_invert}, {31'd0, sub});
    chk({tag, "_cin"},  {31'd0, carry_in}, {31'd0, sub});
    chk({tag, "_hold"}, C, exp_c);
    model(op, a, b, exp_c, exp_z, exp_v, exp_co);
    @(posedge clk); #1;
    chk({tag, "_C"},    C,                   exp_c);
    chk({tag, "_zero"}, {31'd0, zero},      {31'd0, exp_z});
    chk({tag, "_ovf"},  {31'd0, overflow},  {31'd0, exp_v});
    chk({tag, "_cout"}, {31'd0, carry_out}, {31'd0, exp_co});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset asserted from time zero with ADD 5+3 presented
    rst_n = 1'b0; operation = 3'd2; A = 32'd5; B = 32'd3;
    #1;
    chk("rst_C",    C,                   32'd0);
    chk("rst_zero", {31'd0, zero},      32'd0);
    chk("rst_ovf",  {31'd0, overflow},  32'd0);
    chk("rst_cout", {31'd0, carry_out}, 32'd0);
    chk("rst_binv", {31'd0, B_invert},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge_C", C, 32'd0);
    rst_n = 1'b1;
    exp_c = 32'd0; exp_z = 1'b0; exp_v = 1'b0; exp_co = 1'b0;
    @(posedge clk); #1;
    chk("rel_C", C, 32'd8);
    exp_c = 32'd8;

    // A=0, B=1 across every opcode
    for (int op = 0; op < 8; op++) step(3'(op), 32'd0, 32'd1, "sweep");

    // all-ones operands
    step(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_add");
    step(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_sub");
    step(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_xor");
    step(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_nor");
    step(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_and");
    step(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_slt");

    // signed overflow corners
    step(3'd2, 32'h7FFF_FFFF, 32'd1, "ovf_add");
    step(3'd6, 32'h8000_0000, 32'd1, "ovf_sub");

    // compare signedness
    step(3'd7, 32'hFFFF_FFFF, 32'd1, "slt_neg");
    step(3'd5, 32'hFFFF_FFFF, 32'd1, "sltu_big");

    // asynchronous reset mid-cycle after a nonzero result
    step(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_arst");
    #2; rst_n = 1'b0;
    #1;
    chk("arst_C",    C,                  32'd0);
    chk("arst_zero", {31'd0, zero},     32'd0);
    #2; rst_n = 1'b1;
    exp_c = 32'd0; exp_z = 1'b0; exp_v = 1'b0; exp_co = 1'b0;
    step(3'd2, 32'd5, 32'd3, "post_arst");

    // randomized back-to-back operations
    for (int i = 0; i < 300; i++) step(3'($urandom_range(0, 7)), pick(), pick(), "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
